// File: rtl/music_play_ctrl.sv
// ---------------------------------------------------------------------------
// music_play_ctrl
//
// Playback sequencer for the FPGA music player. Turns single-cycle key pulses
// and the BCD elapsed-seconds digits from the timer into the timer run/clear
// controls and a one-hot song select. Detects end of song against the
// per-song length parameters LEN0..LEN2.
//
// Build option:
//   MUSIC_AUTO_NEXT_EN  defined   : an end-of-song advances to the next song
//                                   and keeps playing.
//                       undefined : an end-of-song returns to IDLE on the
//                                   same song with the timer cleared.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RST        in   synchronous, active-low reset
//   key_play   in   one-cycle pulse, toggle play/pause
//   key_stop   in   one-cycle pulse, stop and rewind
//   key_next   in   one-cycle pulse, next song
//   key_prev   in   one-cycle pulse, previous song
//   TimerL     in   elapsed seconds, tens digit (BCD)
//   TimerR     in   elapsed seconds, units digit (BCD)
//   Start      out  timer/tone run enable, high only in PLAY
//   timer_clr  out  one-cycle timer clear pulse (held high during reset)
//   en         out  one-hot song select (001/010/100)
//   song_done  out  one-cycle pulse when the current song reaches its length
//   state_o    out  current state code (IDLE=0 PLAY=1 PAUSE=2 SWITCH=3)
//
// Input semantics: each key_* is a single-cycle pulse sampled on the rising
// edge; there is no handshake. When several keys pulse together only the
// highest priority one acts: stop > next > prev > play. Every output is a
// register, so a key sampled at edge n is reflected on the outputs after
// edge n+1.
// ---------------------------------------------------------------------------
module music_play_ctrl #(
  parameter logic [7:0] LEN0 = 8'd30,
  parameter logic [7:0] LEN1 = 8'd45,
  parameter logic [7:0] LEN2 = 8'd60
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       key_play,
  input  logic       key_stop,
  input  logic       key_next,
  input  logic       key_prev,
  input  logic [3:0] TimerL,
  input  logic [3:0] TimerR,
  output logic       Start,
  output logic       timer_clr,
  output logic [2:0] en,
  output logic       song_done,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    PAUSE  = 2'd2,
    SWITCH = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] en_q, en_d;
  logic       start_q, start_d;
  logic       clr_q, clr_d;
  logic       done_q, done_d;
  // mask_q: first PLAY cycle after SWITCH, the timer still shows the old song
  logic       mask_q, mask_d;
  // manual_q: the current SWITCH was entered by next/prev, not by end of song
  logic       manual_q, manual_d;

  // Key priority decode: only one of these can be high.
  logic k_stop, k_next, k_prev, k_play;
  assign k_stop = key_stop;
  assign k_next = !key_stop && key_next;
  assign k_prev = !key_stop && !key_next && key_prev;
  assign k_play = !key_stop && !key_next && !key_prev && key_play;

  // Elapsed seconds; non-BCD digits saturate to 9 so the value stays <= 99.
  logic [3:0] tens_sat, units_sat;
  logic [6:0] elapsed;
  assign tens_sat  = (TimerL > 4'd9) ? 4'd9 : TimerL;
  assign units_sat = (TimerR > 4'd9) ? 4'd9 : TimerR;
  assign elapsed   = ({3'b000, tens_sat} << 3) + ({3'b000, tens_sat} << 1)
                   + {3'b000, units_sat};

  logic [7:0] len_sel;
  always_comb begin
    case (en_q)
      3'b010:  len_sel = LEN1;
      3'b100:  len_sel = LEN2;
      default: len_sel = LEN0;
    endcase
  end

  logic end_hit;
  assign end_hit = ({1'b0, elapsed} >= len_sel);

  logic [2:0] en_fwd, en_back;
  assign en_fwd  = {en_q[1:0], en_q[2]};
  assign en_back = {en_q[0], en_q[2:1]};

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    clr_d    = 1'b0;
    done_d   = 1'b0;
    mask_d   = 1'b0;
    manual_d = manual_q;

    case (state_q)
      IDLE: begin
        if (k_stop) begin
          clr_d = 1'b1;
        end else if (k_next) begin
          en_d  = en_fwd;
          clr_d = 1'b1;
        end else if (k_prev) begin
          en_d  = en_back;
          clr_d = 1'b1;
        end else if (k_play) begin
          state_d = PLAY;
        end
      end

      PLAY: begin
        if (k_stop) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end else if (k_next) begin
          en_d     = en_fwd;
          state_d  = SWITCH;
          manual_d = 1'b1;
        end else if (k_prev) begin
          en_d     = en_back;
          state_d  = SWITCH;
          manual_d = 1'b1;
        end else if (k_play) begin
          state_d = PAUSE;
        end else if (!mask_q && end_hit) begin
          state_d  = SWITCH;
          done_d   = 1'b1;
          manual_d = 1'b0;
        end
      end

      PAUSE: begin
        if (k_stop) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end else if (k_next) begin
          en_d  = en_fwd;
          clr_d = 1'b1;
        end else if (k_prev) begin
          en_d  = en_back;
          clr_d = 1'b1;
        end else if (k_play) begin
          state_d = PLAY;
        end
      end

      SWITCH: begin
        // Keys are ignored for this single cycle.
        if (manual_q) begin
          state_d = PLAY;
          mask_d  = 1'b1;
        end else begin
`ifdef MUSIC_AUTO_NEXT_EN
          en_d    = en_fwd;
          state_d = PLAY;
          mask_d  = 1'b1;
`else
          state_d = IDLE;
`endif
        end
      end

      default: state_d = IDLE;
    endcase

    // SWITCH always clears the timer; Start follows the next state directly.
    if (state_d == SWITCH) clr_d = 1'b1;
    start_d = (state_d == PLAY);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= IDLE;
      en_q     <= 3'b001;
      start_q  <= 1'b0;
      clr_q    <= 1'b1;
      done_q   <= 1'b0;
      mask_q   <= 1'b0;
      manual_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      start_q  <= start_d;
      clr_q    <= clr_d;
      done_q   <= done_d;
      mask_q   <= mask_d;
      manual_q <= manual_d;
    end
  end

  assign Start     = start_q;
  assign timer_clr = clr_q;
  assign en        = en_q;
  assign song_done = done_q;
  assign state_o   = state_q;

endmodule

// File: doc/music_play_ctrl.md
# music_play_ctrl

Playback sequencer for the FPGA music player. It turns single-cycle key pulses (play/pause, stop, next, previous) and the elapsed-time digits from the seconds timer into the timer run/clear controls and the one-hot song select bus. It detects end of song against per-song length parameters. It sits between the debounced key logic and the timer, tone-generator and display datapath.

## Interface
Parameters:
- LEN0, 8'd30: length of song 0 in seconds (binary, 1..99)
- LEN1, 8'd45: length of song 1 in seconds
- LEN2, 8'd60: length of song 2 in seconds

Ports:
- CLK  input  1  system clock; all state changes on rising edge
- RST  input  1  synchronous, active-low reset
- key_play  input  1  one-cycle pulse; toggles play/pause
- key_stop  input  1  one-cycle pulse; stop and rewind
- key_next  input  1  one-cycle pulse; select next song
- key_prev  input  1  one-cycle pulse; select previous song
- TimerL  input  4  elapsed seconds, tens digit, BCD
- TimerR  input  4  elapsed seconds, units digit, BCD
- Start  output  1  timer/tone run enable; high only in PLAY
- timer_clr  output  1  one-cycle pulse; clears the timer to 00
- en  output  3  one-hot song select (001 = song 0, 010 = song 1, 100 = song 2)
- song_done  output  1  one-cycle pulse when the current song reaches its length
- state_o  output  2  current state code, for debug/LEDs

## Operation
- States: IDLE=0, PLAY=1, PAUSE=2, SWITCH=3. All outputs are registered.
- Reset values (RST=0 at an edge): state IDLE, Start=0, timer_clr=1, en=001, song_done=0. timer_clr is held at 1 during reset and drops on the first edge after release.
- Elapsed time: elapsed = TimerL*10 + TimerR, 7-bit binary. The length is selected by en. A non-BCD digit (greater than 9) is treated as 9.
- Key priority when several keys pulse in one cycle: stop > next > prev > play. Only the highest-priority key acts.
- IDLE:
  - play → PLAY.
  - next/prev → rotate en (next: 001→010→100→001; prev: reverse) and pulse timer_clr; stay in IDLE.
  - stop → pulse timer_clr.
- PLAY:
  - play → PAUSE.
  - stop → IDLE with timer_clr pulse.
  - next/prev → rotate en and go to SWITCH.
  - elapsed >= length → pulse song_done and go to SWITCH.
- PAUSE:
  - play → PLAY.
  - stop → IDLE with timer_clr pulse.
  - next/prev → rotate en, pulse timer_clr, stay in PAUSE.
  - No end detection in PAUSE.
- SWITCH: lasts exactly one cycle. timer_clr=1 and Start=0. Keys pulsed in this cycle are ignored. The next state depends on the configuration (below); a manual next/prev always returns to PLAY.
- End of song is checked only in PLAY, and is masked in the first PLAY cycle after SWITCH so a stale timer value cannot re-trigger it.
- If end of song and a key occur in the same cycle, the key wins and song_done is not pulsed.

## Timing
- Key pulse at edge n → new state, Start, en and timer_clr are visible after edge n+1 (1-cycle latency).
- End detected at edge n → song_done=1 and timer_clr=1 for the single cycle after edge n+1 → Start=1 again after edge n+2 (with auto-advance).
- timer_clr is always exactly one cycle wide, except while RST is asserted.
- Reset taken mid-PLAY returns all outputs to their reset values at that edge; in-progress state is discarded.

## Configuration
- MUSIC_AUTO_NEXT_EN defined: after an end-of-song SWITCH, en rotates to the next song (100 wraps to 001) and the state returns to PLAY, giving continuous playback.
- MUSIC_AUTO_NEXT_EN undefined: after an end-of-song SWITCH, en is unchanged and the state goes to IDLE. The timer is cleared and Start=0.
- Manual next/prev behaviour is identical in both builds.

## Test plan
- Reset then release; pulse key_play → after 1 cycle Start=1, state_o=1, en=001, timer_clr=0.
- In PLAY with LEN0=30, drive TimerL=3, TimerR=0 → song_done and timer_clr pulse one cycle. With the macro: en=010, Start=1 two cycles later. Without the macro: state_o=0, Start=0, en=001.
- In PLAY, pulse key_stop and key_next in the same cycle → IDLE, timer_clr pulse, en unchanged at 001.
- In PAUSE, pulse key_prev with en=001 → en=100, timer_clr pulse, Start stays 0, state_o=2; pulse key_play → Start=1.
- In PLAY, assert key_next in the same cycle that elapsed equals the length → en advances once, song_done stays 0.
- Assert RST=0 mid-PLAY for one cycle → Start=0, en=001, timer_clr=1, state_o=0; first edge after release gives timer_clr=0.
